// File: rtl/ldpc_ctrl_pkg.sv
// Shared constants and state encoding for the LDPC iteration scheduler.
// Geometry defaults describe the R x C block-row array with D-sized circulants.
package ldpc_ctrl_pkg;

    localparam int LDPC_R        = 5;
    localparam int LDPC_C        = 3;
    localparam int LDPC_D        = 8;
    localparam int LDPC_MAX_ITER = 10;
    localparam int LDPC_CNU_LAT  = 2;
    localparam int LDPC_VNU_LAT  = 2;
    localparam int LDPC_ITER_W   = 4;
    localparam int LDPC_ADDR_W   = (LDPC_R > 1) ? $clog2(LDPC_R) : 1;

    typedef enum logic [2:0] {
        LDPC_ST_IDLE  = 3'd0,
        LDPC_ST_LOAD  = 3'd1,
        LDPC_ST_CNU   = 3'd2,
        LDPC_ST_VNU   = 3'd3,
        LDPC_ST_CHECK = 3'd4,
        LDPC_ST_DONE  = 3'd5
    } ldpc_state_e;

endpackage

// File: rtl/ldpc_phase_timer.sv
// Loadable down-counter timing one CNU or VNU phase; done marks the phase's last cycle.
module ldpc_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Phase counter: a load wins over the decrement so back-to-back phases chain seamlessly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == W'(1'b1));

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Iteration scheduler for the layered LDPC decoder: LLR load, CNU/VNU phasing, syndrome check, hand-off.
// Build option: define EARLY_TERM_EN to stop as soon as the syndrome check passes.
module ldpc_iter_ctrl
    import ldpc_ctrl_pkg::*;
#(
    parameter int R        = LDPC_R,
    parameter int MAX_ITER = LDPC_MAX_ITER,
    parameter int CNU_LAT  = LDPC_CNU_LAT,
    parameter int VNU_LAT  = LDPC_VNU_LAT,
    parameter int ITER_W   = LDPC_ITER_W,
    parameter int AW       = (R > 1) ? $clog2(R) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    input  logic [ITER_W-1:0] max_iter_cfg,
    output logic              cnu_en,
    output logic              vnu_en,
    output logic              first_iter,
    input  logic              synd_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              converged,
    output logic              busy
);

    localparam int PH_MAX = (CNU_LAT > VNU_LAT) ? CNU_LAT : VNU_LAT;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [2:0] ST_IDLE  = LDPC_ST_IDLE;
    localparam logic [2:0] ST_LOAD  = LDPC_ST_LOAD;
    localparam logic [2:0] ST_CNU   = LDPC_ST_CNU;
    localparam logic [2:0] ST_VNU   = LDPC_ST_VNU;
    localparam logic [2:0] ST_CHECK = LDPC_ST_CHECK;
    localparam logic [2:0] ST_DONE  = LDPC_ST_DONE;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [AW-1:0]     wr_addr_r;
    logic [AW-1:0]     wr_addr_nxt_s;
    logic [ITER_W-1:0] iter_cnt_r;
    logic [ITER_W-1:0] iter_cnt_nxt_s;
    logic [ITER_W-1:0] limit_r;
    logic [ITER_W-1:0] limit_nxt_s;
    logic [ITER_W:0]   iter_inc_s;
    logic              converged_r;
    logic              conv_nxt_s;
    logic              in_ready_r;
    logic              cnu_en_r;
    logic              vnu_en_r;
    logic              first_iter_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              accept_s;
    logic              at_limit_s;
    logic              term_s;
    logic              phase_load_s;
    logic [PH_W-1:0]   phase_val_s;
    logic              phase_done_s;

    assign accept_s   = in_valid & in_ready_r;
    assign wr_en      = accept_s;
    assign in_ready   = in_ready_r;
    assign wr_addr    = wr_addr_r;
    assign cnu_en     = cnu_en_r;
    assign vnu_en     = vnu_en_r;
    assign first_iter = first_iter_r;
    assign out_valid  = out_valid_r;
    assign iter_cnt   = iter_cnt_r;
    assign converged  = converged_r;
    assign busy       = busy_r;

    ldpc_phase_timer #(
        .W (PH_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load_s),
        .load_val (phase_val_s),
        .done     (phase_done_s)
    );

    // Termination decision for the CHECK cycle; the compare is one bit wider so it cannot wrap.
    always_comb begin
        iter_inc_s = {1'b0, iter_cnt_r} + {{ITER_W{1'b0}}, 1'b1};
        at_limit_s = (iter_inc_s >= {1'b0, limit_r});
`ifdef EARLY_TERM_EN
        term_s = at_limit_s | synd_ok;
`else
        term_s = at_limit_s;
`endif
    end

    // Next-state, address, iteration and verdict logic.
    always_comb begin
        state_nxt_s    = state_r;
        wr_addr_nxt_s  = wr_addr_r;
        iter_cnt_nxt_s = iter_cnt_r;
        conv_nxt_s     = converged_r;
        limit_nxt_s    = limit_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    iter_cnt_nxt_s = {ITER_W{1'b0}};
                    conv_nxt_s     = 1'b0;
                    limit_nxt_s    = (max_iter_cfg == {ITER_W{1'b0}}) ? ITER_W'(MAX_ITER) : max_iter_cfg;
                    if (R == 1) begin
                        state_nxt_s   = ST_CNU;
                        wr_addr_nxt_s = {AW{1'b0}};
                    end else begin
                        state_nxt_s   = ST_LOAD;
                        wr_addr_nxt_s = AW'(1'b1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    if (wr_addr_r == AW'(R - 1)) begin
                        state_nxt_s   = ST_CNU;
                        wr_addr_nxt_s = {AW{1'b0}};
                    end else begin
                        wr_addr_nxt_s = wr_addr_r + AW'(1'b1);
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_CNU: begin
                if (phase_done_s) begin
                    state_nxt_s = ST_VNU;
                end else begin
                    state_nxt_s = ST_CNU;
                end
            end
            ST_VNU: begin
                if (phase_done_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_VNU;
                end
            end
            ST_CHECK: begin
                // Saturate rather than wrap; the limit normally stops us well before.
                iter_cnt_nxt_s = (iter_cnt_r == {ITER_W{1'b1}}) ? iter_cnt_r : iter_inc_s[ITER_W-1:0];
                if (term_s) begin
                    state_nxt_s = ST_DONE;
                    conv_nxt_s  = synd_ok;
                end else begin
                    state_nxt_s = ST_CNU;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Arm the phase timer on entry into a CNU or VNU phase.
    always_comb begin
        phase_load_s = 1'b0;
        phase_val_s  = PH_W'(CNU_LAT);
        if ((state_nxt_s == ST_CNU) && (state_r != ST_CNU)) begin
            phase_load_s = 1'b1;
            phase_val_s  = PH_W'(CNU_LAT);
        end else if ((state_nxt_s == ST_VNU) && (state_r != ST_VNU)) begin
            phase_load_s = 1'b1;
            phase_val_s  = PH_W'(VNU_LAT);
        end else begin
            phase_load_s = 1'b0;
        end
    end

    // State and output registers; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            wr_addr_r    <= {AW{1'b0}};
            iter_cnt_r   <= {ITER_W{1'b0}};
            limit_r      <= {ITER_W{1'b0}};
            converged_r  <= 1'b0;
            in_ready_r   <= 1'b1;
            cnu_en_r     <= 1'b0;
            vnu_en_r     <= 1'b0;
            first_iter_r <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wr_addr_r    <= wr_addr_nxt_s;
            iter_cnt_r   <= iter_cnt_nxt_s;
            limit_r      <= limit_nxt_s;
            converged_r  <= conv_nxt_s;
            in_ready_r   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_LOAD);
            cnu_en_r     <= (state_nxt_s == ST_CNU);
            vnu_en_r     <= (state_nxt_s == ST_VNU);
            first_iter_r <= ((state_nxt_s == ST_CNU) || (state_nxt_s == ST_VNU) ||
                             (state_nxt_s == ST_CHECK)) && (iter_cnt_nxt_s == {ITER_W{1'b0}});
            out_valid_r  <= (state_nxt_s == ST_DONE);
            busy_r       <= (state_nxt_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl: load patterns, iteration limits, early stop, DONE hold and mid-frame reset.
module tb_ldpc_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] max_iter_cfg = 4'd0;
    logic       cnu_en;
    logic       vnu_en;
    logic       first_iter;
    logic       synd_ok = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] iter_cnt;
    logic       converged;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    ldpc_iter_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .max_iter_cfg (max_iter_cfg),
        .cnu_en       (cnu_en),
        .vnu_en       (vnu_en),
        .first_iter   (first_iter),
        .synd_ok      (synd_ok),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .iter_cnt     (iter_cnt),
        .converged    (converged),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the first accepted beat; synd_ok pulses only in the CHECK cycle of iteration synd_iter.
    task automatic run_frame(input string tag, input logic [3:0] cfg, input bit toggle,
                             input int synd_iter, input int hold, input int exp_iter,
                             input int exp_conv, input int exp_last_acc, input int exp_lat);
        int cyc = 0;
        int acc = 0;
        int last_acc = -1;
        int cnu_run = 0;
        int vnu_run = 0;
        int pairs = 0;
        int bad_run = 0;
        int overlap = 0;
        int fi_cyc = 0;
        int fi_cnu = 0;
        int cnu_start = -1;
        int lat = -1;
        int addr_bad = 0;
        int bad_hold = 0;
        bit is_check;
        logic [3:0] it_hold;
        logic cv_hold;
        max_iter_cfg = cfg;
        out_ready = 1'b0;
        while (lat < 0 && cyc < 2000) begin
            if (out_valid) begin
                lat = cyc;
            end else begin
                is_check = 1'b0;
                if (cnu_en && vnu_en) overlap++;
                if (cnu_en) begin
                    if (cnu_start < 0) cnu_start = cyc;
                    cnu_run++;
                end else if (cnu_run != 0) begin
                    if (cnu_run != 2) bad_run++;
                    cnu_run = 0;
                end
                if (vnu_en) begin
                    vnu_run++;
                end else if (vnu_run != 0) begin
                    if (vnu_run != 2) bad_run++;
                    vnu_run = 0;
                    pairs++;
                    is_check = 1'b1;
                end
                if (first_iter) begin
                    fi_cyc++;
                    if (cnu_en) fi_cnu++;
                end
                in_valid = toggle ? ((cyc % 3) == 0) : 1'b1;
                synd_ok = is_check && (pairs == synd_iter);
                #1;
                if (wr_en) begin
                    if (int'(wr_addr) != acc) addr_bad++;
                    acc++;
                    last_acc = cyc;
                end
                tick;
                cyc++;
            end
        end
        synd_ok = 1'b0;
        check_val({tag, ".out_valid_seen"}, (lat >= 0), 1);
        check_val({tag, ".latency"}, lat, exp_lat);
        check_val({tag, ".accepts"}, acc, 5);
        check_val({tag, ".addr_order"}, addr_bad, 0);
        check_val({tag, ".last_accept"}, last_acc, exp_last_acc);
        check_val({tag, ".cnu_start"}, cnu_start, exp_last_acc + 1);
        check_val({tag, ".phase_len"}, bad_run, 0);
        check_val({tag, ".overlap"}, overlap, 0);
        check_val({tag, ".pairs"}, pairs, exp_iter);
        check_val({tag, ".first_iter_cyc"}, fi_cyc, 5);
        check_val({tag, ".first_iter_cnu"}, fi_cnu, 2);
        check_val({tag, ".iter_cnt"}, iter_cnt, exp_iter);
        check_val({tag, ".converged"}, converged, exp_conv);
        it_hold = iter_cnt;
        cv_hold = converged;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            #1;
            if (!out_valid || (iter_cnt !== it_hold) || (converged !== cv_hold) || in_ready || wr_en)
                bad_hold++;
            tick;
        end
        check_val({tag, ".done_hold"}, bad_hold, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check_val({tag, ".post_in_ready"}, in_ready, 1);
        check_val({tag, ".post_out_valid"}, out_valid, 0);
        check_val({tag, ".post_busy"}, busy, 0);
        check_val({tag, ".post_iter_held"}, iter_cnt, exp_iter);
    endtask

    initial begin
        #12;
        check_val("rst.in_ready", in_ready, 1);
        check_val("rst.out_valid", out_valid, 0);
        check_val("rst.busy", busy, 0);
        check_val("rst.cnu_vnu", {cnu_en, vnu_en, first_iter}, 0);
        check_val("rst.iter_conv", {iter_cnt, converged}, 0);
        check_val("rst.wr_addr", wr_addr, 0);
        tick;
        rst = 1'b1;
        tick;

        run_frame("full", 4'd0, 1'b0, 0, 7, 10, 0, 4, 55);
`ifdef EARLY_TERM_EN
        run_frame("synd3", 4'd0, 1'b0, 3, 0, 3, 1, 4, 20);
`else
        run_frame("synd3", 4'd0, 1'b0, 3, 0, 10, 0, 4, 55);
`endif
        run_frame("toggle", 4'd0, 1'b1, 0, 0, 10, 0, 12, 63);
        run_frame("cfg2", 4'd2, 1'b0, 0, 0, 2, 0, 4, 15);

        // Abort a frame during VNU of iteration 4 (cycles 22-23), asynchronously.
        max_iter_cfg = 4'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 22; k++) tick;
        check_val("abort.in_vnu4", vnu_en, 1);
        check_val("abort.iter3", iter_cnt, 3);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("abort.in_ready", in_ready, 1);
        check_val("abort.phases", {cnu_en, vnu_en, first_iter, out_valid, busy}, 0);
        check_val("abort.iter_cnt", iter_cnt, 0);
        tick;
        rst = 1'b1;
        tick;
        run_frame("after_rst", 4'd0, 1'b0, 0, 0, 10, 0, 4, 55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ldpc_iter_ctrl.md
Name: ldpc_iter_ctrl

Overview:
Iteration scheduler for the layered CNU/VNU LDPC decoder array (R=5 block rows, C=3 block columns, D=8 circulant size).
- Accepts a channel-LLR frame over a valid/ready stream and issues write strobes to the LLR buffer.
- Alternates CNU and VNU phase enables for a bounded number of iterations.
- Samples the syndrome check and presents the decoded frame over a valid/ready handshake.
- Sits beside the decoder top and drives its phase enables; contains no datapath.

Parameters:
R, 5, block rows; number of LLR load beats per frame
D, 8, circulant size (informational; carried in package)
MAX_ITER, 10, default iteration limit
CNU_LAT, 2, cycles cnu_en is held per phase (>=1)
VNU_LAT, 2, cycles vnu_en is held per phase (>=1)
ITER_W, 4, iteration counter width; must hold MAX_ITER

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  LLR beat valid
in_ready  out  1  controller accepts LLR beat
wr_en  out  1  LLR buffer write strobe (= in_valid & in_ready)
wr_addr  out  clog2(R)  LLR buffer beat address
max_iter_cfg  in  ITER_W  runtime iteration limit; 0 selects MAX_ITER
cnu_en  out  1  check-node update phase enable
vnu_en  out  1  variable-node update phase enable
first_iter  out  1  high throughout iteration 1 (VNU selects channel LLR)
synd_ok  in  1  all-zero syndrome from hard decisions
out_valid  out  1  decoded frame valid
out_ready  in  1  downstream accepts frame
iter_cnt  out  ITER_W  completed iterations of current/last frame
converged  out  1  final syndrome was zero
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, CNU, VNU, CHECK, DONE. Reset (rst=0, async): state IDLE; all outputs 0 except in_ready=1; counters 0.
- IDLE: in_ready=1. Accepted beat (in_valid) writes addr 0; if R==1 go to CNU, else go to LOAD with wr_addr=1. Clear iter_cnt and converged on that beat. Latch the limit: max_iter_cfg, or MAX_ITER when it is 0.
- LOAD: in_ready=1. Each accepted beat writes wr_addr, then increments it. A stalled in_valid holds state. Accepting beat R-1 moves to CNU next cycle; wr_addr wraps to 0.
- CNU: cnu_en=1 for exactly CNU_LAT cycles (phase down-counter), then VNU.
- VNU: vnu_en=1 for exactly VNU_LAT cycles, then CHECK. cnu_en and vnu_en are never high together.
- CHECK: one cycle; iter_cnt increments; synd_ok sampled this cycle.
  - If termination holds (see Optional Feature) or iter_cnt+1 == limit: go to DONE; converged <= synd_ok.
  - Otherwise go to CNU.
- first_iter = 1 from CNU entry of iteration 1 until CHECK of iteration 1, inclusive.
- DONE: out_valid=1, held stable until out_ready. Handshake cycle goes to IDLE. iter_cnt and converged hold until the next frame's first beat.
- in_ready=0 in CNU/VNU/CHECK/DONE; in_valid there is ignored.
- Latency, no stalls, frame not converged: R + limit*(CNU_LAT+VNU_LAT+1) cycles from first beat to out_valid.
- iter_cnt saturates at 2^ITER_W-1; the limit guarantees no wrap.
- Reset mid-frame: immediate IDLE, pending frame discarded, out_valid drops asynchronously.

Optional Feature:
- Macro EARLY_TERM_EN.
- Defined: CHECK terminates when synd_ok=1 or the limit is reached.
- Undefined: always runs the full limit; synd_ok affects only converged, sampled at the final CHECK.

Decomposition:
- Package ldpc_ctrl_pkg holds:
  - state enum (3-bit)
  - R, C, D defaults
  - ITER_W and clog2(R) address-width constants
- One sub-module, ldpc_phase_timer: loadable down-counter with a done pulse, shared by the CNU and VNU phases.

Test Plan:
- Reset then 5 beats with in_valid always high, synd_ok=0, cfg=0 -> wr_addr 0..4; cnu_en exactly 2 cycles then vnu_en 2 cycles per iteration; out_valid at cycle 5+10*5=55; iter_cnt=10, converged=0.
- EARLY_TERM_EN, synd_ok=1 at CHECK of iteration 3 -> DONE after 3 iterations, iter_cnt=3, converged=1. Same stimulus without the macro -> iter_cnt=10, converged per final sample.
- in_valid toggling 1,0,0,1,... during LOAD -> wr_en only on high cycles, wr_addr advances only on accepts, CNU begins after the 5th accept.
- max_iter_cfg=2 -> exactly 2 CNU/VNU pairs, iter_cnt=2. first_iter high only during the first pair.
- out_ready held 0 for 7 cycles in DONE -> out_valid, iter_cnt, converged stable; in_ready=0. After handshake, in_ready=1 next cycle.
- rst asserted during VNU of iteration 4 -> outputs zero immediately, in_ready=1. A new frame decodes normally from iteration 1.
